// File: rtl/syn_current_accumulator.sv
// Sums a stream of sign-magnitude synaptic current terms into one neuron input current,
// holding the finished sum on a valid/ready output until the consumer takes it.
module syn_current_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [16:0]      acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;
  logic [16:0]      sum_r;
  logic [CNT_W-1:0] count_r;
  logic             osat_r;
  logic [17:0]      add_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             accept_s;

  // Returns {clamp, sign, magnitude}; zero operands and results are always treated as +0.
  function automatic logic [17:0] sm_add(input logic [16:0] a, input logic [16:0] b,
                                         input logic sub);
    logic [15:0] a_mag;
    logic [15:0] b_mag;
    logic [15:0] mag;
    logic [16:0] wide;
    logic        a_sgn;
    logic        b_sgn;
    logic        sgn;
    logic        clamp;
    a_mag = a[15:0];
    b_mag = b[15:0];
    a_sgn = a[16] & (a_mag != 16'h0000);
    b_sgn = (b[16] ^ sub) & (b_mag != 16'h0000);
    wide  = {1'b0, a_mag} + {1'b0, b_mag};
    clamp = 1'b0;
    if (a_sgn == b_sgn) begin
      sgn = a_sgn;
      if (wide[16]) begin
        mag   = 16'hFFFF;
        clamp = 1'b1;
      end else begin
        mag = wide[15:0];
      end
    end else if (a_mag >= b_mag) begin
      sgn = a_sgn;
      mag = a_mag - b_mag;
    end else begin
      sgn = b_sgn;
      mag = b_mag - a_mag;
    end
    if (mag == 16'h0000) begin
      sgn = 1'b0;
    end else begin
      sgn = sgn;
    end
    return {clamp, sgn, mag};
  endfunction

  assign accept_s  = (state_r == ACC) && in_valid;
  assign add_s     = sm_add(acc_r, in_data, in_sub);
  assign cnt_inc_s = (&cnt_r) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACC;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    if (clr) begin
      state_next_s = ACC;
    end else begin
      case (state_r)
        ACC:     state_next_s = (in_valid && in_last) ? HOLD : ACC;
        HOLD:    state_next_s = out_ready ? ACC : HOLD;
        default: state_next_s = ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      ACC: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Running sum and the captured result; clr wins over any same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= 17'h00000;
      cnt_r   <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
      sum_r   <= 17'h00000;
      count_r <= {CNT_W{1'b0}};
      osat_r  <= 1'b0;
    end else if (clr) begin
      acc_r   <= 17'h00000;
      cnt_r   <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
      sum_r   <= 17'h00000;
      count_r <= {CNT_W{1'b0}};
      osat_r  <= 1'b0;
    end else if (accept_s) begin
      acc_r <= add_s[16:0];
      cnt_r <= cnt_inc_s;
      sat_r <= sat_r | add_s[17];
      if (in_last) begin
        sum_r   <= add_s[16:0];
        count_r <= cnt_inc_s;
        osat_r  <= sat_r | add_s[17];
      end
    end else if ((state_r == HOLD) && out_ready) begin
      acc_r <= 17'h00000;
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end
  end

  assign out_sum   = sum_r;
  assign out_count = count_r;
  assign out_sat   = osat_r;

endmodule

// File: tb/tb_syn_current_accumulator.sv
// Randomised and directed bench for syn_current_accumulator; the reference model
// keeps the sum as a plain signed integer clamped to +/-65535.
module tb_syn_current_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_data = 17'h00000;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_sum;
  logic [7:0]  out_count;
  logic        out_sat;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit m_hold;
  int m_acc, m_cnt, m_osum, m_ocnt;
  bit m_sat, m_osat;

  syn_current_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dec(input logic [16:0] d);
    int mag;
    mag = int'(d[15:0]);
    return d[16] ? -mag : mag;
  endfunction

  function automatic logic [16:0] enc(input int v);
    logic [16:0] r;
    if (v < 0) r = {1'b1, 16'(-v)};
    else       r = {1'b0, 16'(v)};
    return r;
  endfunction

  task automatic model_clear();
    m_hold = 1'b0; m_acc = 0; m_cnt = 0; m_sat = 1'b0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic tick();
    int b, r;
    bit c;
    @(negedge clk);
    chk("in_ready", in_ready, !m_hold);
    chk("out_valid", out_valid, m_hold);
    if (m_hold) begin
      chk("out_sum", out_sum, enc(m_osum));
      chk("out_count", out_count, m_ocnt);
      chk("out_sat", out_sat, m_osat);
    end
    if (clr) begin
      model_clear();
    end else if (!m_hold) begin
      if (in_valid) begin
        b = dec(in_data);
        if (in_sub) b = -b;
        r = m_acc + b;
        c = 1'b0;
        if (r > 65535)  begin r = 65535;  c = 1'b1; end
        if (r < -65535) begin r = -65535; c = 1'b1; end
        m_acc = r;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_sat = m_sat | c;
        if (in_last) begin
          m_osum = m_acc; m_ocnt = m_cnt; m_osat = m_sat; m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      model_clear();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic term(input logic [16:0] d, input logic sub, input logic last);
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
    tick();
    in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [16:0] s, input int n, input logic sat);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_count"}, out_count, n);
    chk({tag, "_sat"}, out_sat, sat);
  endtask

  initial begin
    model_clear();
    m_osum = 0; m_ocnt = 0; m_osat = 1'b0;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_sum", out_sum, 17'h00000);
    chk("rst_count", out_count, 8'd0);
    chk("rst_sat", out_sat, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    term(17'h00600, 1'b0, 1'b0); term(17'h00400, 1'b0, 1'b1);
    expect_out("p6p4", 17'h00A00, 2, 1'b0); drain();
    term(17'h10600, 1'b0, 1'b0); term(17'h00400, 1'b0, 1'b1);
    expect_out("m6p4", 17'h10200, 2, 1'b0); drain();
    term(17'h00600, 1'b0, 1'b0); term(17'h10400, 1'b1, 1'b1);
    expect_out("p6sm4", 17'h00A00, 2, 1'b0); drain();
    term(17'h00400, 1'b0, 1'b0); term(17'h10400, 1'b0, 1'b1);
    expect_out("zero1", 17'h00000, 2, 1'b0); drain();
    term(17'h10400, 1'b0, 1'b0); term(17'h10400, 1'b1, 1'b1);
    expect_out("zero2", 17'h00000, 2, 1'b0); drain();
    term(17'h0C800, 1'b0, 1'b0); term(17'h06400, 1'b0, 1'b0); term(17'h03200, 1'b1, 1'b1);
    expect_out("satur", 17'h0CDFF, 3, 1'b1);

    // backpressure: held output must not move and inputs are refused
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 17'h01234; in_last = i[0];
      tick();
      expect_out("bp", 17'h0CDFF, 3, 1'b1);
      chk("bp_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    term(17'h00100, 1'b0, 1'b1);
    expect_out("after_bp", 17'h00100, 1, 1'b0); drain();

    // abort with a simultaneous valid term
    term(17'h00100, 1'b0, 1'b0); term(17'h00200, 1'b0, 1'b0); term(17'h00300, 1'b0, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 17'h00700; in_last = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_valid", out_valid, 1'b0);
    tick();
    term(17'h00400, 1'b0, 1'b1);
    expect_out("after_clr", 17'h00400, 1, 1'b0); drain();

    // term counter saturates at 255
    for (int i = 0; i < 300; i++) term(17'h00001, i[0], 1'b0);
    term(17'h00002, 1'b0, 1'b1);
    expect_out("cnt_sat", 17'h00002, 255, 1'b0); drain();

    // asynchronous reset while holding a result
    term(17'h00900, 1'b0, 1'b1);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("async_valid", out_valid, 1'b0);
    chk("async_ready", in_ready, 1'b1);
    chk("async_sum", out_sum, 17'h00000);
    #1;
    rst_n = 1'b1;
    model_clear();
    tick();

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_sub    = $urandom_range(1, 0);
      in_last   = ($urandom_range(5, 0) == 0);
      out_ready = ($urandom_range(2, 0) != 0);
      clr       = ($urandom_range(49, 0) == 0);
      case ($urandom_range(3, 0))
        0:       in_data = {1'($urandom_range(1, 0)), 16'h0000};
        1:       in_data = {1'($urandom_range(1, 0)), 16'($urandom_range(65535, 49152))};
        default: in_data = 17'($urandom);
      endcase
      tick();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0; in_last = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
